// File: rtl/mem_sweep_bist.sv
// Memory sweep self-test engine: a second bus master that writes a pattern over a
// window of RAM, reads it back, and reports the mismatch count and first failing address.
module mem_sweep_bist #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH      = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    RD_LATENCY = 1,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [1:0]            mode_i,
  input  logic                  bus_gnt_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  bus_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  mem_we_o,
  output logic                  mem_oe_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [CNT_WIDTH-1:0]  fail_count_o,
  output logic [ADDR_WIDTH-1:0] first_fail_addr_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WR,
    S_RD,
    S_RDWAIT,
    S_REL
  } state_t;

  localparam int                    LAT_W     = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [LAT_W-1:0]      LAST_WAIT = LAT_W'(RD_LATENCY - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [LAT_W-1:0]      wait_q, wait_d;
  logic [1:0]            mode_q, mode_d;
  logic [CNT_WIDTH-1:0]  fail_count_q, fail_count_d;
  logic [ADDR_WIDTH-1:0] first_fail_q, first_fail_d;
  logic                  pass_q, pass_d;

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] walk_pos;
  logic [DATA_WIDTH-1:0] idx_rep;
  logic [DATA_WIDTH-1:0] cb_pat;
  logic [DATA_WIDTH-1:0] walk_pat;
  logic [DATA_WIDTH-1:0] pat;

  // Address arithmetic wraps naturally at 2^ADDR_WIDTH.
  assign cur_addr = BASE_ADDR + idx_q;
  assign walk_pos = idx_q % ADDR_WIDTH'(DATA_WIDTH);

  // Index is truncated or replicated bit-wise to fill the data width.
  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_pat
    assign idx_rep[gi]  = idx_q[gi % ADDR_WIDTH];
    assign cb_pat[gi]   = idx_q[0] ^ ((gi % 2) == 0);
    assign walk_pat[gi] = (walk_pos == ADDR_WIDTH'(gi));
  end

  always_comb begin
    pat = idx_rep;
    unique case (mode_q)
      2'd0: pat = ~idx_rep;
      2'd1: pat = cb_pat;
      2'd2: pat = idx_rep;
      2'd3: pat = walk_pat;
      default: pat = idx_rep;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      wait_q       <= '0;
      mode_q       <= '0;
      fail_count_q <= '0;
      first_fail_q <= '0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wait_q       <= wait_d;
      mode_q       <= mode_d;
      fail_count_q <= fail_count_d;
      first_fail_q <= first_fail_d;
      pass_q       <= pass_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wait_d       = wait_q;
    mode_d       = mode_q;
    fail_count_d = fail_count_q;
    first_fail_d = first_fail_q;
    pass_d       = pass_q;
    bus_req_o    = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    mem_we_o     = 1'b0;
    mem_oe_o     = 1'b0;
    done_o       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d      = S_REQ;
          mode_d       = mode_i;
          idx_d        = '0;
          wait_d       = '0;
          fail_count_d = '0;
          first_fail_d = '0;
          pass_d       = 1'b0;
        end
      end

      S_REQ: begin
        bus_req_o = 1'b1;
        if (bus_gnt_i) state_d = S_WR;
      end

      S_WR: begin
        bus_req_o   = 1'b1;
        mem_addr_o  = cur_addr;
        mem_wdata_o = pat;
        if (bus_gnt_i) begin
          mem_we_o = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_RD;
          end else begin
            idx_d = idx_q + ADDR_WIDTH'(1);
          end
        end
      end

      S_RD: begin
        bus_req_o  = 1'b1;
        mem_addr_o = cur_addr;
        if (bus_gnt_i) begin
          mem_oe_o = 1'b1;
          wait_d   = '0;
          state_d  = S_RDWAIT;
        end
      end

      S_RDWAIT: begin
        bus_req_o  = 1'b1;
        mem_addr_o = cur_addr;
        if (!bus_gnt_i) begin
          // Losing the grant mid-read discards the access; it is reissued from RD.
          wait_d  = '0;
          state_d = S_RD;
        end else begin
          mem_oe_o = 1'b1;
          if (wait_q == LAST_WAIT) begin
            if (mem_rdata_i != pat) begin
              if (fail_count_q != CNT_MAX) fail_count_d = fail_count_q + CNT_WIDTH'(1);
              if (fail_count_q == '0) first_fail_d = cur_addr;
            end
            if (idx_q == LAST_IDX) begin
              state_d = S_REL;
            end else begin
              idx_d   = idx_q + ADDR_WIDTH'(1);
              state_d = S_RD;
            end
          end else begin
            wait_d = wait_q + LAT_W'(1);
          end
        end
      end

      S_REL: begin
        done_o  = 1'b1;
        pass_d  = (fail_count_q == '0);
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o            = (state_q != S_IDLE);
  assign pass_o            = pass_q;
  assign fail_count_o      = fail_count_q;
  assign first_fail_addr_o = first_fail_q;

endmodule
